// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline control bus between the hazard sequencer and the 5-stage datapath.
// master = hazard controller, slave = datapath stage registers / PC.
interface pipeline_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             ex_memread;
   logic [4:0]       ex_rt;
   logic             mem_branch;
   logic             mem_zero;
   logic             mem_jump;
   logic             mem_req;
   logic             mem_ready;

   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             ex_mem_flush;
   logic [1:0]       pc_sel;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   modport master (
      input  id_rs, id_rt, ex_memread, ex_rt, mem_branch, mem_zero, mem_jump,
             mem_req, mem_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, pc_sel, mem_err,
             stall_cnt, flush_cnt
   );

   modport slave (
      output id_rs, id_rt, ex_memread, ex_rt, mem_branch, mem_zero, mem_jump,
             mem_req, mem_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             if_id_flush, id_ex_flush, ex_mem_flush, pc_sel, mem_err,
             stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage MIPS pipeline: memory-wait freeze with
// timeout, MEM-stage redirects, load-use bubbles and saturating perf counters.
module pipeline_hazard_ctrl #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   pipeline_hazard_ctrl_if.master io_hz
);

   localparam int              WC_W   = $clog2(TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

   typedef enum logic {
      RUN     = 1'b0,
      MEMWAIT = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_nxt_state;
   logic [WC_W-1:0]  r_wait_cnt;
   logic [WC_W-1:0]  w_nxt_wait;
   logic             r_mem_err;
   logic             w_set_err;
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic             w_taken;
   logic             w_load_use;
   logic             w_hold;
   logic             w_pc_en;
   logic             w_if_id_en;
   logic             w_id_ex_en;
   logic             w_ex_mem_en;
   logic             w_mem_wb_en;
   logic             w_if_id_flush;
   logic             w_id_ex_flush;
   logic             w_ex_mem_flush;
   logic [1:0]       w_pc_sel;
   logic             w_redirect;

   assign w_taken    = (io_hz.mem_branch & io_hz.mem_zero) | io_hz.mem_jump;
   assign w_load_use = io_hz.ex_memread && (io_hz.ex_rt != 5'd0) &&
                       ((io_hz.ex_rt == io_hz.id_rs) || (io_hz.ex_rt == io_hz.id_rt));

   // Freeze: a new unfinished access in RUN, or an ongoing wait not yet timed out.
   always_comb begin
      if (r_state == RUN) w_hold = io_hz.mem_req & ~io_hz.mem_ready;
      else                w_hold = ~io_hz.mem_ready && (r_wait_cnt != WC_MAX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= RUN;
         r_wait_cnt <= '0;
      end else begin
         r_state    <= w_nxt_state;
         r_wait_cnt <= w_nxt_wait;
      end
   end

   always_comb begin
      w_nxt_state    = RUN;
      w_nxt_wait     = '0;
      w_set_err      = 1'b0;
      w_redirect     = 1'b0;
      w_pc_en        = 1'b1;
      w_if_id_en     = 1'b1;
      w_id_ex_en     = 1'b1;
      w_ex_mem_en    = 1'b1;
      w_mem_wb_en    = 1'b1;
      w_if_id_flush  = 1'b0;
      w_id_ex_flush  = 1'b0;
      w_ex_mem_flush = 1'b0;
      w_pc_sel       = 2'b00;

      if (rst) begin
         w_pc_en     = 1'b0;
         w_if_id_en  = 1'b0;
         w_id_ex_en  = 1'b0;
         w_ex_mem_en = 1'b0;
         w_mem_wb_en = 1'b0;
      end else if (w_hold) begin
         w_pc_en     = 1'b0;
         w_if_id_en  = 1'b0;
         w_id_ex_en  = 1'b0;
         w_ex_mem_en = 1'b0;
         w_mem_wb_en = 1'b0;
         w_nxt_state = MEMWAIT;
         w_nxt_wait  = (r_state == RUN) ? WC_W'(1) : r_wait_cnt + 1'b1;
      end else begin
         // Released without ready while waiting means the timeout fired.
         if (r_state == MEMWAIT && !io_hz.mem_ready) w_set_err = 1'b1;
         if (w_taken) begin
            w_redirect     = 1'b1;
            w_if_id_flush  = 1'b1;
            w_id_ex_flush  = 1'b1;
            w_ex_mem_flush = 1'b1;
            w_pc_sel       = io_hz.mem_jump ? 2'b10 : 2'b01;
         end else if (w_load_use) begin
            w_pc_en       = 1'b0;
            w_if_id_en    = 1'b0;
            w_id_ex_flush = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mem_err   <= 1'b0;
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_set_err) r_mem_err <= 1'b1;
         if (!w_pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_redirect && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign io_hz.pc_en        = w_pc_en;
   assign io_hz.if_id_en     = w_if_id_en;
   assign io_hz.id_ex_en     = w_id_ex_en;
   assign io_hz.ex_mem_en    = w_ex_mem_en;
   assign io_hz.mem_wb_en    = w_mem_wb_en;
   assign io_hz.if_id_flush  = w_if_id_flush;
   assign io_hz.id_ex_flush  = w_id_ex_flush;
   assign io_hz.ex_mem_flush = w_ex_mem_flush;
   assign io_hz.pc_sel       = w_pc_sel;
   assign io_hz.mem_err      = r_mem_err;
   assign io_hz.stall_cnt    = r_stall_cnt;
   assign io_hz.flush_cnt    = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: default DUT plus a TIMEOUT=4 / CNT_W=3 DUT sharing the same inputs.
module tb_pipeline_hazard_ctrl;

   logic clk;
   logic rst;
   int   err_cnt;
   int   chk_cnt;

   pipeline_hazard_ctrl_if #(.CNT_W(16)) bus ();
   pipeline_hazard_ctrl_if #(.CNT_W(3))  bus4 ();

   assign bus4.id_rs      = bus.id_rs;
   assign bus4.id_rt      = bus.id_rt;
   assign bus4.ex_memread = bus.ex_memread;
   assign bus4.ex_rt      = bus.ex_rt;
   assign bus4.mem_branch = bus.mem_branch;
   assign bus4.mem_zero   = bus.mem_zero;
   assign bus4.mem_jump   = bus.mem_jump;
   assign bus4.mem_req    = bus.mem_req;
   assign bus4.mem_ready  = bus.mem_ready;

   pipeline_hazard_ctrl #(.CNT_W(16), .TIMEOUT(64)) u_dut (
      .clk   (clk),
      .rst   (rst),
      .io_hz (bus)
   );

   pipeline_hazard_ctrl #(.CNT_W(3), .TIMEOUT(4)) u_dut4 (
      .clk   (clk),
      .rst   (rst),
      .io_hz (bus4)
   );

   logic [4:0] en, en4;
   logic [2:0] fl;
   assign en  = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en};
   assign en4 = {bus4.pc_en, bus4.if_id_en, bus4.id_ex_en, bus4.ex_mem_en, bus4.mem_wb_en};
   assign fl  = {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic idle();
      bus.id_rs      = 5'd0;
      bus.id_rt      = 5'd0;
      bus.ex_memread = 1'b0;
      bus.ex_rt      = 5'd0;
      bus.mem_branch = 1'b0;
      bus.mem_zero   = 1'b0;
      bus.mem_jump   = 1'b0;
      bus.mem_req    = 1'b0;
      bus.mem_ready  = 1'b0;
   endtask

   initial begin
      err_cnt = 0;
      chk_cnt = 0;
      rst     = 1'b1;
      idle();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_en",     32'(en),  32'h00);
      chk("rst_fl",     32'(fl),  32'h0);
      chk("rst_sel",    32'(bus.pc_sel), 32'h0);
      chk("rst_stall",  32'(bus.stall_cnt), 32'h0);
      chk("rst_flush",  32'(bus.flush_cnt), 32'h0);
      chk("rst_err",    32'(bus.mem_err), 32'h0);

      @(negedge clk); rst = 1'b0; #1;
      chk("run_en", 32'(en), 32'h1f);

      // load-use: lw $2 in EX, ID reads $2
      @(negedge clk);
      bus.ex_memread = 1'b1; bus.ex_rt = 5'd2; bus.id_rs = 5'd2; bus.id_rt = 5'd7; #1;
      chk("lu_en",    32'(en), 32'h07);
      chk("lu_fl",    32'(fl), 32'h2);
      chk("lu_stall0", 32'(bus.stall_cnt), 32'h0);
      @(negedge clk); bus.ex_memread = 1'b0; #1;
      chk("lu_stall1", 32'(bus.stall_cnt), 32'h1);
      chk("lu_bubble_en", 32'(en), 32'h1f);

      // $zero destination never stalls
      @(negedge clk);
      bus.ex_memread = 1'b1; bus.ex_rt = 5'd0; bus.id_rs = 5'd0; #1;
      chk("r0_en", 32'(en), 32'h1f);
      chk("r0_fl", 32'(fl), 32'h0);

      // taken branch, then not-taken
      @(negedge clk);
      idle(); bus.mem_branch = 1'b1; bus.mem_zero = 1'b1; #1;
      chk("br_sel", 32'(bus.pc_sel), 32'h1);
      chk("br_fl",  32'(fl), 32'h7);
      chk("br_en",  32'(en), 32'h1f);
      @(negedge clk); bus.mem_zero = 1'b0; #1;
      chk("br_fcnt", 32'(bus.flush_cnt), 32'h1);
      chk("nt_sel",  32'(bus.pc_sel), 32'h0);
      chk("nt_fl",   32'(fl), 32'h0);

      // jump + branch + load-use in one cycle: jump wins, no stall
      @(negedge clk);
      bus.mem_branch = 1'b1; bus.mem_zero = 1'b1; bus.mem_jump = 1'b1;
      bus.ex_memread = 1'b1; bus.ex_rt = 5'd5; bus.id_rt = 5'd5; #1;
      chk("jmp_sel", 32'(bus.pc_sel), 32'h2);
      chk("jmp_fl",  32'(fl), 32'h7);
      chk("jmp_en",  32'(en), 32'h1f);
      @(negedge clk); idle(); #1;
      chk("jmp_fcnt",  32'(bus.flush_cnt), 32'h2);
      chk("jmp_stall", 32'(bus.stall_cnt), 32'h1);

      // memory wait: 5 cycles not ready; the TIMEOUT=4 copy releases on cycle 5
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk); bus.mem_req = 1'b1; bus.mem_ready = 1'b0; #1;
         chk($sformatf("mw_en_%0d", i), 32'(en), 32'h00);
         chk($sformatf("mw_fl_%0d", i), 32'(fl), 32'h0);
         chk($sformatf("to_en_%0d", i), 32'(en4), (i <= 4) ? 32'h00 : 32'h1f);
      end
      @(negedge clk); bus.mem_ready = 1'b1; #1;
      chk("mw_rdy_en", 32'(en),  32'h1f);
      chk("to_rdy_en", 32'(en4), 32'h1f);
      @(negedge clk); idle(); #1;
      chk("mw_stall", 32'(bus.stall_cnt),  32'd6);
      chk("to_stall", 32'(bus4.stall_cnt), 32'd5);
      chk("mw_err",   32'(bus.mem_err),    32'h0);
      chk("to_err",   32'(bus4.mem_err),   32'h1);

      // more waiting: 3-bit counter saturates at 7, then reset mid-wait
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk); bus.mem_req = 1'b1; bus.mem_ready = 1'b0; #1;
         chk($sformatf("w2_en4_%0d", i), 32'(en4), 32'h00);
      end
      @(negedge clk); #1;
      chk("sat_main_stall", 32'(bus.stall_cnt),  32'd10);
      chk("sat_to_stall",   32'(bus4.stall_cnt), 32'd7);
      chk("sat_to_fcnt",    32'(bus4.flush_cnt), 32'd2);
      chk("w2_main_en",     32'(en),  32'h00);
      chk("w2_to_rel_en",   32'(en4), 32'h1f);
      rst = 1'b1; #1;
      chk("amid_en",    32'(en),  32'h00);
      chk("amid_en4",   32'(en4), 32'h00);
      chk("amid_sel",   32'(bus.pc_sel), 32'h0);
      chk("amid_stall", 32'(bus.stall_cnt), 32'h0);
      chk("amid_flush", 32'(bus.flush_cnt), 32'h0);
      chk("amid_err4",  32'(bus4.mem_err),  32'h0);
      chk("amid_st4",   32'(bus4.stall_cnt), 32'h0);
      @(negedge clk); rst = 1'b0; idle(); #1;
      chk("post_rst_en", 32'(en), 32'h1f);
      @(negedge clk); #1;
      chk("post_rst_stall", 32'(bus.stall_cnt), 32'h0);

      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule
